// File: rtl/sync_debounce_edge.sv
// sync_debounce_edge
// Conditions a raw asynchronous input for the downstream sticky set flop.
// The input passes through a two-flop synchroniser. A new level is accepted
// only after STABLE_CNT consecutive qualified samples agree. The block drives
// a registered debounced level, one-cycle RISE/FALL pulses and a BUSY flag.
module sync_debounce_edge #(
   parameter int STABLE_CNT = 4,
   parameter int CW         = 3
) (
   input  logic CK,
   input  logic RST,
   input  logic DIN,
   input  logic EN,
   output logic LVL,
   output logic RISE,
   output logic FALL,
   output logic BUSY
);

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      CHK_HI  = 2'd1,
      IDLE_HI = 2'd2,
      CHK_LO  = 2'd3
   } state_t;

   // Last count value before acceptance. The counter never passes it.
   localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

   logic          r_s1;
   logic          r_s2;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_lvl;
   logic          r_rise;
   logic          r_fall;
   logic          r_busy;

   state_t        w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_lvl_nxt;
   logic          w_rise_nxt;
   logic          w_fall_nxt;

   // Two-flop synchroniser. It keeps running while EN is low, so it holds
   // fresh data when qualification resumes.
   always_ff @(posedge CK) begin
      if (RST) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= DIN;
         r_s2 <= r_s1;
      end
   end

   // Next-state and output decode. While EN is low, everything holds and the
   // pulses stay 0. Any disagreeing sample during a check returns the FSM to
   // idle, so a partial count is never carried forward.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_lvl_nxt   = r_lvl;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      if (EN) begin
         case (r_state)
            IDLE_LO: begin
               if (r_s2) begin
                  w_state_nxt = CHK_HI;
                  w_cnt_nxt   = CW'(1);
               end
            end
            CHK_HI: begin
               if (!r_s2) begin
                  w_state_nxt = IDLE_LO;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == LAST) begin
                  w_state_nxt = IDLE_HI;
                  w_cnt_nxt   = '0;
                  w_lvl_nxt   = 1'b1;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt   = r_cnt + CW'(1);
               end
            end
            IDLE_HI: begin
               if (!r_s2) begin
                  w_state_nxt = CHK_LO;
                  w_cnt_nxt   = CW'(1);
               end
            end
            CHK_LO: begin
               if (r_s2) begin
                  w_state_nxt = IDLE_HI;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == LAST) begin
                  w_state_nxt = IDLE_LO;
                  w_cnt_nxt   = '0;
                  w_lvl_nxt   = 1'b0;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt   = r_cnt + CW'(1);
               end
            end
            default: begin
               w_state_nxt = IDLE_LO;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State register and registered outputs. BUSY is decoded from the next
   // state so that it lines up with the state it describes.
   always_ff @(posedge CK) begin
      if (RST) begin
         r_state <= IDLE_LO;
         r_cnt   <= '0;
         r_lvl   <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_lvl   <= w_lvl_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
         r_busy  <= (w_state_nxt == CHK_HI) || (w_state_nxt == CHK_LO);
      end
   end

   assign LVL  = r_lvl;
   assign RISE = r_rise;
   assign FALL = r_fall;
   assign BUSY = r_busy;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// tb_sync_debounce_edge
// Directed scenarios with literal expectations, followed by randomized
// bouncing input. The bench compares the DUT on every cycle against a
// run-length model of the debouncer.
module tb_sync_debounce_edge;

   localparam int STABLE_CNT = 4;
   localparam int CW         = 3;

   logic CK = 1'b0;
   logic RST;
   logic DIN;
   logic EN;
   logic LVL;
   logic RISE;
   logic FALL;
   logic BUSY;

   int nchk = 0;
   int nerr = 0;

   sync_debounce_edge #(.STABLE_CNT(STABLE_CNT), .CW(CW)) dut (
      .CK   (CK),
      .RST  (RST),
      .DIN  (DIN),
      .EN   (EN),
      .LVL  (LVL),
      .RISE (RISE),
      .FALL (FALL),
      .BUSY (BUSY)
   );

   always #5 CK = ~CK;

   task automatic chk(input string nm, input logic act, input logic exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at t=%0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   // Model. A delay line holds the captured DIN history. The debouncer is
   // modelled as a run length of enabled samples that disagree with the
   // current level. When the run reaches STABLE_CNT, the level flips.
   bit dq[$];
   bit s2;
   bit m_valid = 1'b0;
   bit m_lvl, m_rise, m_fall;
   int m_run;

   always @(posedge CK) begin
      if (RST) begin
         dq = '{1'b0, 1'b0};
         m_lvl = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         dq.push_front(DIN);
         s2 = dq[2];
         void'(dq.pop_back());
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (EN) begin
            if (s2 != m_lvl) begin
               m_run++;
               if (m_run == STABLE_CNT) begin
                  m_lvl  = s2;
                  m_rise = s2;
                  m_fall = !s2;
                  m_run  = 0;
               end
            end else begin
               m_run = 0;
            end
         end
      end
   end

   // Compare the DUT against the model on every cycle once reset has been seen.
   always @(negedge CK) begin
      if (m_valid) begin
         chk("LVL",  LVL,  m_lvl);
         chk("RISE", RISE, m_rise);
         chk("FALL", FALL, m_fall);
         chk("BUSY", BUSY, m_run != 0);
         chk("EXCL", RISE & FALL, 1'b0);
      end
   end

   task automatic run(input logic d, input logic e, input int n);
      DIN = d; EN = e;
      repeat (n) @(negedge CK);
   endtask

   initial begin
      RST = 1'b1; DIN = 1'b0; EN = 1'b1;
      @(negedge CK);                 // reset edge
      chk("rst_lvl",  LVL,  1'b0);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_rise", RISE, 1'b0);
      RST = 1'b0;
      @(negedge CK);                 // edge 1
      DIN = 1'b1;                    // captured at edge 2
      for (int e = 2; e <= 8; e++) begin
         @(negedge CK);
         chk("t1_busy", BUSY, (e >= 4) && (e <= 6));
         chk("t1_lvl",  LVL,  e >= 7);
         chk("t1_rise", RISE, e == 7);
      end

      // A short low glitch is rejected.
      run(1'b0, 1'b1, 2);
      run(1'b1, 1'b1, 10);
      chk("glitch_lvl", LVL, 1'b1);

      // A stable low input produces FALL at capture+5.
      DIN = 1'b0;
      for (int i = 0; i <= 6; i++) begin
         @(negedge CK);
         chk("fall_pulse", FALL, i == 5);
         chk("fall_norise", RISE, 1'b0);
      end
      chk("fall_lvl", LVL, 1'b0);
      run(1'b0, 1'b1, 4);

      // Bouncing input. RISE comes 5 edges after the last 0->1 capture.
      begin
         logic [5:0] bpat;
         bpat = 6'b101101;
         for (int i = 5; i >= 0; i--) run(bpat[i], 1'b1, 1);
      end
      DIN = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge CK);
         chk("bounce_rise", RISE, i == 5);
      end

      // EN drop during qualification holds the count.
      run(1'b0, 1'b1, 10);
      run(1'b1, 1'b1, 4);            // edges k..k+3, count now 2
      EN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CK);
         chk("en_hold_rise", RISE, 1'b0);
         chk("en_hold_busy", BUSY, 1'b1);
      end
      EN = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge CK);
         chk("en_resume_rise", RISE, i == 2);
      end

      // Reset mid-qualification aborts it. A fresh qualification follows.
      run(1'b0, 1'b1, 10);
      run(1'b1, 1'b1, 5);            // edges k..k+4, count now 3
      RST = 1'b1;
      @(negedge CK);
      chk("midrst_lvl",  LVL,  1'b0);
      chk("midrst_rise", RISE, 1'b0);
      chk("midrst_busy", BUSY, 1'b0);
      RST = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge CK);
         chk("postrst_rise", RISE, i == 6);
      end

      // Randomized bursts: random hold lengths produce both bounce and
      // stable stretches, with occasional EN drops and resets.
      for (int c = 0; c < 4000; ) begin
         int   len;
         logic d;
         len = $urandom_range(1, 8);
         d   = 1'($urandom_range(0, 1));
         for (int j = 0; j < len; j++) begin
            DIN = d;
            EN  = ($urandom_range(0, 9) != 0);
            RST = ($urandom_range(0, 199) == 0);
            @(negedge CK);
            c++;
         end
      end
      RST = 1'b0;
      run(1'b0, 1'b1, 10);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
